mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: default widths, burst limit
// and the ownership state encoding.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF    = 12;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned BURST_LEN_DEF = 4;

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } own_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous SRAM (1-cycle read
// latency). Port 0 is the Wishbone debug port, port 1 the datapath.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_debug,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    own_e              state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              conflict;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    assign conflict = p0_req & p1_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OWN1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q counts conflict grants already given to the owner; the grant
    // that would make it BURST_LEN hands ownership over instead.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (wbs_debug) begin
            cnt_d = cnt_q;
        end else if (conflict) begin
            if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                state_d = (state_q == OWN0) ? OWN1 : OWN0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (p0_req) begin
            state_d = OWN0;
        end else if (p1_req) begin
            state_d = OWN1;
        end
    end

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (rst_n) begin
            if (wbs_debug) begin
                p0_gnt = p0_req;
                p1_gnt = p1_req & ~p0_req;
            end else if (conflict) begin
                p0_gnt = (state_q == OWN0);
                p1_gnt = (state_q == OWN1);
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    assign mem_csb   = ~(p0_gnt | p1_gnt);
    assign mem_web   = p0_gnt ? ~p0_we : (p1_gnt ? ~p1_we : 1'b1);
    assign mem_addr  = p0_gnt ? p0_addr : p1_addr;
    assign mem_wdata = p0_gnt ? p0_wdata : p1_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= p0_gnt & ~p0_we;
            rvalid1_q <= p1_gnt & ~p1_we;
            if (rvalid0_q) rdata0_q <= mem_rdata;
            if (rvalid1_q) rdata1_q <= mem_rdata;
        end
    end

    // SRAM data arrives in the rvalid cycle; the registers only hold it afterwards.
    assign p0_rvalid = rvalid0_q;
    assign p1_rvalid = rvalid1_q;
    assign p0_rdata  = rvalid0_q ? mem_rdata : rdata0_q;
    assign p1_rdata  = rvalid1_q ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural arbitration and memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned BL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wbs_debug = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_csb, mem_web;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .wbs_debug(wbs_debug),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM environment model
    logic [DW-1:0] sram [0:4095];
    always @(posedge clk) begin
        if (!mem_csb) begin
            if (!mem_web) sram[mem_addr] <= mem_wdata;
            else          mem_rdata <= sram[mem_addr];
        end
    end

    // Reference model state: expected memory contents and arbitration history
    logic [DW-1:0] ref_mem [0:4095];
    int            m_owner;
    int            m_streak;

    typedef struct {
        bit            g0, g1, csb, web, rv0, rv1;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cyc_t;

    cyc_t          cyc_q[$];
    logic [DW-1:0] rd_q0[$], rd_q1[$];
    bit            pend0, pend1;
    bit            check_en = 1'b0;
    int            n_cmp = 0, n_bad = 0;
    int            w0 = 0, w1 = 0;
    cyc_t          mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner of a cycle: -1 none, 0 or 1. The owner keeps winning conflicts
    // until it has won BL of them in a row; a lone requester becomes owner.
    function automatic int ref_arb(input bit r0, input bit r1, input bit dbg);
        int win;
        if (!r0 && !r1) begin
            if (!dbg) m_streak = 0;
            return -1;
        end
        if (dbg) return r0 ? 0 : 1;
        if (r0 && r1) begin
            win = m_owner;
            m_streak++;
            if (m_streak == BL) begin
                m_owner  = 1 - m_owner;
                m_streak = 0;
            end
            return win;
        end
        win      = r0 ? 0 : 1;
        m_owner  = win;
        m_streak = 0;
        return win;
    endfunction

    task automatic drive(input bit r0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit r1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input bit dbg);
        cyc_t e;
        int   win;
        @(posedge clk);
        #1;
        p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
        wbs_debug = dbg;
        win     = ref_arb(r0, r1, dbg);
        e.g0    = (win == 0);
        e.g1    = (win == 1);
        e.csb   = (win < 0);
        e.rv0   = pend0;
        e.rv1   = pend1;
        e.web   = 1'b1;
        e.addr  = '0;
        e.wdata = '0;
        pend0   = 1'b0;
        pend1   = 1'b0;
        if (win == 0) begin
            e.web = !we0; e.addr = a0; e.wdata = d0;
            if (we0) ref_mem[a0] = d0;
            else begin rd_q0.push_back(ref_mem[a0]); pend0 = 1'b1; end
        end else if (win == 1) begin
            e.web = !we1; e.addr = a1; e.wdata = d1;
            if (we1) ref_mem[a1] = d1;
            else begin rd_q1.push_back(ref_mem[a1]); pend1 = 1'b1; end
        end
        cyc_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    // Monitor: compares each driven cycle and every presented read response
    always @(negedge clk) begin
        if (check_en) begin
            if (cyc_q.size() > 0) begin
                mon_e = cyc_q.pop_front();
                check("p0_gnt", p0_gnt, mon_e.g0);
                check("p1_gnt", p1_gnt, mon_e.g1);
                check("mem_csb", mem_csb, mon_e.csb);
                check("mem_web", mem_web, mon_e.web);
                if (!mon_e.csb) check("mem_addr", mem_addr, mon_e.addr);
                if (!mon_e.web) check("mem_wdata", mem_wdata, mon_e.wdata);
                check("p0_rvalid", p0_rvalid, mon_e.rv0);
                check("p1_rvalid", p1_rvalid, mon_e.rv1);
            end
            check("gnt_onehot", p0_gnt & p1_gnt, 0);
            if (p0_rvalid) begin
                if (rd_q0.size() == 0) check("p0_rvalid_unexpected", 1, 0);
                else check("p0_rdata", p0_rdata, rd_q0.pop_front());
            end
            if (p1_rvalid) begin
                if (rd_q1.size() == 0) check("p1_rvalid_unexpected", 1, 0);
                else check("p1_rdata", p1_rdata, rd_q1.pop_front());
            end
            if (wbs_debug) begin
                w0 = 0;
                w1 = 0;
            end else begin
                w0 = (p0_req && !p0_gnt) ? w0 + 1 : 0;
                w1 = (p1_req && !p1_gnt) ? w1 + 1 : 0;
                if (p0_req) check("p0_wait_bound", w0 > BL, 0);
                if (p1_req) check("p1_wait_bound", w1 > BL, 0);
            end
        end
    end

    bit exp_p1_seq [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};

    initial begin
        bit            dbg;
        bit            r0, r1, we0, we1;
        logic [AW-1:0] a0, a1;

        for (int i = 0; i < 4096; i++) begin
            sram[i]    = (i * 32'h9E3779B9) ^ 32'h0BADF00D;
            ref_mem[i] = (i * 32'h9E3779B9) ^ 32'h0BADF00D;
        end
        sram[16]    = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        m_owner  = 1;
        m_streak = 0;

        // Reset state with both ports requesting
        p0_req = 1'b1;
        p1_req = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_p0_gnt", p0_gnt, 0);
        check("rst_p1_gnt", p1_gnt, 0);
        check("rst_mem_csb", mem_csb, 1);
        check("rst_mem_web", mem_web, 1);
        check("rst_p0_rvalid", p0_rvalid, 0);
        check("rst_p1_rvalid", p1_rvalid, 0);
        check("rst_p0_rdata", p0_rdata, 0);
        check("rst_p1_rdata", p1_rdata, 0);
        p0_req = 1'b0;
        p1_req = 1'b0;
        rst_n  = 1'b1;
        check_en = 1'b1;

        // Continuous conflict from reset: four grants each, starting with port 1
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, AW'($urandom_range(0, 4095)), '0, 1, 0, AW'($urandom_range(0, 4095)), '0, 0);
            @(negedge clk);
            #1;
            check("burst_seq_p1_gnt", p1_gnt, exp_p1_seq[k]);
        end

        // Lone port 1 read of 0x010
        drive(0, 0, '0, '0, 1, 0, 12'h010, '0, 0);
        idle();
        @(negedge clk);
        #1;
        check("p1_read_010_rvalid", p1_rvalid, 1);
        check("p1_read_010_rdata", p1_rdata, 32'hDEADBEEF);

        // Write from port 0 then read-after-write from port 1
        drive(1, 1, 12'h3FF, 32'hA5A5A5A5, 0, 0, '0, '0, 0);
        @(negedge clk);
        #1;
        check("raw_write_web", mem_web, 0);
        drive(0, 0, '0, '0, 1, 0, 12'h3FF, '0, 0);
        @(negedge clk);
        #1;
        check("raw_read_web", mem_web, 1);
        idle();
        @(negedge clk);
        #1;
        check("raw_p1_rdata", p1_rdata, 32'hA5A5A5A5);

        // Debug mode: port 0 strict priority, then port 1 first once it drops
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, AW'($urandom_range(0, 63)), '0, 1, 0, AW'($urandom_range(0, 63)), '0, 1);
            @(negedge clk);
            #1;
            check("dbg_p0_gnt", p0_gnt, 1);
            check("dbg_p1_gnt", p1_gnt, 0);
        end
        drive(1, 0, 12'h001, '0, 1, 0, 12'h002, '0, 0);
        @(negedge clk);
        #1;
        check("dbg_exit_p1_first", p1_gnt, 1);
        idle();
        idle();

        // Reset pulse immediately after a port 0 read grant
        drive(1, 0, 12'h005, '0, 0, 0, '0, '0, 0);
        #1;
        check("pre_rst_p0_gnt", p0_gnt, 1);
        check_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("pulse_p0_gnt", p0_gnt, 0);
        check("pulse_mem_csb", mem_csb, 1);
        check("pulse_mem_web", mem_web, 1);
        check("pulse_p0_rvalid", p0_rvalid, 0);
        check("pulse_p0_rdata", p0_rdata, 0);
        p0_req = 1'b0;
        #4;
        rst_n = 1'b1;
        cyc_q.delete();
        rd_q0.delete();
        rd_q1.delete();
        pend0    = 1'b0;
        pend1    = 1'b0;
        m_owner  = 1;
        m_streak = 0;
        w0       = 0;
        w1       = 0;
        check_en = 1'b1;
        drive(1, 0, 12'h007, '0, 1, 0, 12'h008, '0, 0);
        @(negedge clk);
        #1;
        check("post_rst_owner_p1", p1_gnt, 1);
        check("post_rst_no_p0_rvalid", p0_rvalid, 0);

        // Random traffic
        dbg = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 49) == 0) dbg = !dbg;
            r0  = ($urandom_range(0, 3) != 0);
            r1  = ($urandom_range(0, 3) != 0);
            we0 = $urandom_range(0, 1) != 0;
            we1 = $urandom_range(0, 1) != 0;
            a0  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 4095));
            a1  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 4095));
            drive(r0, we0, a0, DW'($urandom), r1, we1, a1, DW'($urandom), dbg);
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        check("rd_q0_drained", rd_q0.size(), 0);
        check("rd_q1_drained", rd_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
